// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display types, swap FSM states and framebuffer constants
package display_pkg;

  localparam int PIX_W = 12;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;

  // read-return owner encoding carried by the tag pipeline
  localparam logic OWNER_DISP = 1'b0;
  localparam logic OWNER_RND  = 1'b1;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    RENDER   = 2'd0,
    WAIT_VBL = 2'd1,
    SWAP     = 2'd2
  } swap_state_e;

  // saturating increment for the missed-frame counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - RD_LAT-deep shift register of {valid, owner} read tags
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_owner,
  output logic o_valid,
  output logic o_owner
);

  logic [RD_LAT-1:0] r_valid;
  logic [RD_LAT-1:0] r_owner;

  // shift one tag per cycle so it emerges alongside the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_owner <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_owner[0] <= i_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_owner[i] <= r_owner[i-1];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_owner = r_owner[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port framebuffer arbiter with display priority and double buffering
module vram_arbiter
  import display_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic              rnd_we,
  input  logic [ADDR_W-1:0] rnd_addr,
  input  logic [DATA_W-1:0] rnd_wdata,
  output logic [DATA_W-1:0] rnd_rdata,
  output logic              rnd_rvalid,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              buf_sel,
  output logic [7:0]        drop_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  swap_state_e       r_state;
  logic              r_buf_sel;
  logic [7:0]        r_drop_cnt;
  logic              r_swap_done;
  logic [DATA_W-1:0] r_disp_rdata;
  logic              r_disp_rvalid;
  logic [DATA_W-1:0] r_rnd_rdata;
  logic              r_rnd_rvalid;

  logic w_rnd_ready;
  logic w_rnd_fire;
  logic w_rd_issue;
  logic w_rd_owner;
  logic w_tag_valid;
  logic w_tag_owner;

  // renderer only gets the port in RENDER and only when the display is idle
  assign w_rnd_ready = (r_state == RENDER) && !disp_req;
  assign w_rnd_fire  = rnd_valid && w_rnd_ready;

  // a read is tagged whether it comes from the display or the renderer
  assign w_rd_issue  = disp_req || (w_rnd_fire && !rnd_we);
  assign w_rd_owner  = disp_req ? OWNER_DISP : OWNER_RND;

  // RAM port mux: display wins, renderer targets the back buffer
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = {r_buf_sel, disp_addr};
    end else if (w_rnd_fire) begin
      mem_en    = 1'b1;
      mem_we    = rnd_we;
      mem_addr  = {~r_buf_sel, rnd_addr};
      mem_wdata = rnd_we ? rnd_wdata : '0;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_rd_issue),
    .i_owner (w_rd_owner),
    .o_valid (w_tag_valid),
    .o_owner (w_tag_owner)
  );

  // register returning RAM data to whichever requester owns the emerging tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_rdata  <= '0;
      r_disp_rvalid <= 1'b0;
      r_rnd_rdata   <= '0;
      r_rnd_rvalid  <= 1'b0;
    end else begin
      r_disp_rvalid <= w_tag_valid && (w_tag_owner == OWNER_DISP);
      r_rnd_rvalid  <= w_tag_valid && (w_tag_owner == OWNER_RND);
      if (w_tag_valid && (w_tag_owner == OWNER_DISP)) begin
        r_disp_rdata <= mem_rdata;
      end
      if (w_tag_valid && (w_tag_owner == OWNER_RND)) begin
        r_rnd_rdata <= mem_rdata;
      end
    end
  end

  // swap FSM: buffers flip only at vblank; vblanks without a finished frame are counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RENDER;
      r_buf_sel   <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        RENDER: begin
          if (swap_req && frame_start) begin
            r_state     <= SWAP;
            r_buf_sel   <= ~r_buf_sel;
            r_swap_done <= 1'b1;
          end else if (swap_req) begin
            r_state <= WAIT_VBL;
          end else if (frame_start) begin
            r_drop_cnt <= sat_inc8(r_drop_cnt);
          end
        end
        WAIT_VBL: begin
          if (frame_start) begin
            r_state     <= SWAP;
            r_buf_sel   <= ~r_buf_sel;
            r_swap_done <= 1'b1;
          end
        end
        SWAP: begin
          r_state <= RENDER;
        end
        default: begin
          r_state <= RENDER;
        end
      endcase
    end
  end

  assign rnd_ready   = w_rnd_ready;
  assign buf_sel     = r_buf_sel;
  assign drop_cnt    = r_drop_cnt;
  assign swap_done   = r_swap_done;
  assign disp_rdata  = r_disp_rdata;
  assign disp_rvalid = r_disp_rvalid;
  assign rnd_rdata   = r_rnd_rdata;
  assign rnd_rvalid  = r_rnd_rvalid;

endmodule
